// File: rtl/backprop_pkg.sv
// Shared types and helpers for the backprop error path: FSM states, default Q format, result reduction.
// Configuration: ERROR_SATURATE_EN selects clamping of results; otherwise results wrap to WIDTH bits.
// No logic of its own; latency and backpressure are defined by the modules that import it.
package backprop_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        DONE = 2'd2
    } mvm_state_t;

    localparam int DEF_WIDTH    = 8;
    localparam int DEF_FRACTION = 4;

    // Callers keep the low `width` bits of the returned value.
    function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] acc,
                                                     input int width);
`ifdef ERROR_SATURATE_EN
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (acc > hi) return hi;
        if (acc < lo) return lo;
        return acc;
`else
        return acc & ((64'sd1 <<< width) - 64'sd1);
`endif
    endfunction

endpackage

// File: rtl/fixed_mac.sv
// Signed multiply-accumulate; sum = acc + a*b is combinational, the accumulator is registered.
// Latency: one cycle per accumulate step; clear loads zero instead of the new sum.
// No backpressure: accumulates on every cycle en is high.
module fixed_mac #(
    parameter int WIDTH = 8,
    parameter int ACC_W = 18
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic                    clear,
    input  logic signed [WIDTH-1:0] a,
    input  logic signed [WIDTH-1:0] b,
    output logic signed [ACC_W-1:0] sum
);

    logic signed [2*WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]   acc_q;

    assign prod = a * b;
    assign sum  = acc_q + ACC_W'(prod);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
        end else if (en) begin
            acc_q <= clear ? '0 : sum;
        end
    end

endmodule

// File: rtl/error_backprop_mvm.sv
// Sequential e = W^T * delta, one signed MAC per cycle; result reduction set by ERROR_SATURATE_EN.
// Latency: NUM_ROWS*NUM_COLS + 1 cycles from input handshake to out_valid.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE, busy in_valid ignored.
module error_backprop_mvm
    import backprop_pkg::*;
#(
    parameter int NUM_ROWS = 4,
    parameter int NUM_COLS = 3,
    parameter int WIDTH    = DEF_WIDTH,
    parameter int FRACTION = DEF_FRACTION
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [NUM_ROWS*NUM_COLS*WIDTH-1:0] matrix,
    input  logic [NUM_COLS*WIDTH-1:0]      delta,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [NUM_ROWS*WIDTH-1:0]      error
);

    localparam int ACC_W = 2*WIDTH + $clog2(NUM_COLS);
    localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
    localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;

    mvm_state_t                         state;
    logic [ROW_W-1:0]                   row;
    logic [COL_W-1:0]                   col;
    logic [NUM_ROWS*NUM_COLS*WIDTH-1:0] m_q;
    logic [NUM_COLS*WIDTH-1:0]          d_q;
    logic [NUM_ROWS*WIDTH-1:0]          err_q;

    int                      m_idx;
    int                      d_idx;
    int                      e_idx;
    logic                    last_col;
    logic                    last_row;
    logic signed [WIDTH-1:0] m_elem;
    logic signed [WIDTH-1:0] d_elem;
    logic signed [ACC_W-1:0] sum;
    logic signed [ACC_W-1:0] res;
    logic [WIDTH-1:0]        res_red;

    always_comb begin
        m_idx = (int'(row) * NUM_COLS + int'(col)) * WIDTH;
        d_idx = int'(col) * WIDTH;
        e_idx = int'(row) * WIDTH;
    end

    assign last_col = (col == COL_W'(NUM_COLS - 1));
    assign last_row = (row == ROW_W'(NUM_ROWS - 1));
    assign m_elem   = m_q[m_idx +: WIDTH];
    assign d_elem   = d_q[d_idx +: WIDTH];
    assign res      = sum >>> FRACTION;
    assign res_red  = WIDTH'(sat_trunc(64'(res), WIDTH));
    assign error    = err_q;

    fixed_mac #(
        .WIDTH (WIDTH),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state == MAC),
        .clear (last_col),
        .a     (m_elem),
        .b     (d_elem),
        .sum   (sum)
    );

    // DONE spends one cycle settling before out_valid rises, so the last row is
    // stable for a full cycle before it is presented.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            m_q       <= '0;
            d_q       <= '0;
            err_q     <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        m_q      <= matrix;
                        d_q      <= delta;
                        row      <= '0;
                        col      <= '0;
                        in_ready <= 1'b0;
                        state    <= MAC;
                    end
                end
                MAC: begin
                    if (last_col) begin
                        err_q[e_idx +: WIDTH] <= res_red;
                        col                   <= '0;
                        if (last_row) begin
                            row   <= '0;
                            state <= DONE;
                        end else begin
                            row <= row + 1'b1;
                        end
                    end else begin
                        col <= col + 1'b1;
                    end
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_error_backprop_mvm.sv
// Scoreboard bench for error_backprop_mvm: directed and random operand sets against a floor-division reference.
module tb_error_backprop_mvm;

    localparam int R   = 4;
    localparam int C   = 3;
    localparam int W   = 8;
    localparam int F   = 4;
    localparam int LAT = R*C + 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [R*C*W-1:0] matrix = '0;
    logic [C*W-1:0]   delta = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [R*W-1:0]   err_vec;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_hs = 0;

    logic [R*W-1:0] exp_q[$];
    int             hs_q[$];

    error_backprop_mvm #(
        .NUM_ROWS (R),
        .NUM_COLS (C),
        .WIDTH    (W),
        .FRACTION (F)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .matrix    (matrix),
        .delta     (delta),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .error     (err_vec)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // e[r] = floor(sum_c m[r][c]*d[c] / 2^F), then clamp or wrap to W bits
    function automatic logic [R*W-1:0] model(input logic [R*C*W-1:0] m, input logic [C*W-1:0] d);
        logic [R*W-1:0] e;
        e = '0;
        for (int r = 0; r < R; r++) begin
            longint s;
            logic signed [W-1:0] a;
            logic signed [W-1:0] b;
            logic [63:0] sv;
            s = 0;
            for (int c = 0; c < C; c++) begin
                a = m[(r*C + c)*W +: W];
                b = d[c*W +: W];
                s += longint'(a) * longint'(b);
            end
            s = s >>> F;
`ifdef ERROR_SATURATE_EN
            if (s > 127) s = 127;
            if (s < -128) s = -128;
`endif
            sv = s;
            e[r*W +: W] = sv[W-1:0];
        end
        return e;
    endfunction

    // Call at posedge+1; returns at posedge+1 just after the handshake edge.
    task automatic send(input logic [R*C*W-1:0] m, input logic [C*W-1:0] d, input bit keep);
        int n;
        matrix   = m;
        delta    = d;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", n);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        last_hs = cyc;
        hs_q.push_back(cyc);
        exp_q.push_back(model(m, d));
        if (!keep) in_valid = 1'b0;
    endtask

    task automatic drain(input bit rnd);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            @(posedge clk); #1;
            out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
            n++;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        hs_q.delete();
    endtask

    function automatic logic [R*C*W-1:0] rand_mat();
        logic [R*C*W-1:0] m;
        for (int i = 0; i < R*C; i++) m[i*W +: W] = W'($urandom);
        return m;
    endfunction

    function automatic logic [C*W-1:0] rand_vec();
        logic [C*W-1:0] d;
        for (int i = 0; i < C; i++) d[i*W +: W] = W'($urandom);
        return d;
    endfunction

    function automatic logic [R*C*W-1:0] fill_mat(input logic [W-1:0] v);
        logic [R*C*W-1:0] m;
        for (int i = 0; i < R*C; i++) m[i*W +: W] = v;
        return m;
    endfunction

    function automatic logic [C*W-1:0] fill_vec(input logic [W-1:0] v);
        logic [C*W-1:0] d;
        for (int i = 0; i < C; i++) d[i*W +: W] = v;
        return d;
    endfunction

    // Monitor: pops one expectation per accepted output and times out_valid rise.
    logic prev_ov = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_ov = 1'b0;
        end else begin
            check("ready_valid_exclusive", 64'(in_ready && out_valid), 64'd0);
            if (out_valid && !prev_ov) begin
                if (hs_q.size() != 0) begin
                    int h;
                    h = hs_q.pop_front();
                    check("latency", 64'(cyc - h), 64'(LAT));
                end else begin
                    total++; bad++;
                    $display("FAIL unexpected_valid: out_valid rose with no outstanding request (cycle %0d)", cyc);
                end
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() != 0) begin
                    check("error_vec", 64'(err_vec), 64'(exp_q.pop_front()));
                end else begin
                    total++; bad++;
                    $display("FAIL unexpected_output: error=%0h with empty scoreboard", err_vec);
                end
            end
            prev_ov = out_valid;
        end
    end

    initial begin
        logic [R*C*W-1:0] m;
        logic [R*W-1:0]   held;
        int               h1;
        int               n;

        #12;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_error", 64'(err_vec), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Ramp matrix, unit delta
        for (int i = 0; i < R*C; i++) m[i*W +: W] = W'(i);
        send(m, fill_vec(8'h01), 1'b0);
        drain(1'b0);

        // 1.0 * 0.5 summed over three columns
        send(fill_mat(8'h10), fill_vec(8'h08), 1'b0);
        drain(1'b0);

        send(fill_mat(8'h7F), fill_vec(8'h7F), 1'b0);
        drain(1'b0);
        send(fill_mat(8'h80), fill_vec(8'h7F), 1'b0);
        drain(1'b0);

        // Backpressure: hold result 20 cycles, ignore a busy in_valid pulse
        out_ready = 1'b0;
        send(rand_mat(), rand_vec(), 1'b0);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("bp_valid_seen", 64'(out_valid), 64'd1);
        held = err_vec;
        for (int i = 0; i < 20; i++) begin
            if (i == 5) begin
                matrix   = rand_mat();
                delta    = rand_vec();
                in_valid = 1'b1;
            end
            if (i == 6) in_valid = 1'b0;
            @(posedge clk); #1;
            check("bp_error_stable", 64'(err_vec), 64'(held));
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("bp_in_ready_after", 64'(in_ready), 64'd1);
        check("bp_valid_dropped", 64'(out_valid), 64'd0);
        drain(1'b0);

        // Asynchronous reset in MAC cycle 5
        send(rand_mat(), rand_vec(), 1'b0);
        repeat (4) begin
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_in_ready", 64'(in_ready), 64'd1);
        check("rst_mid_out_valid", 64'(out_valid), 64'd0);
        check("rst_mid_error", 64'(err_vec), 64'd0);
        void'(exp_q.pop_back());
        void'(hs_q.pop_back());
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(rand_mat(), rand_vec(), 1'b0);
        drain(1'b0);

        // Back-to-back with in_valid and out_ready held high
        send(rand_mat(), rand_vec(), 1'b1);
        h1 = last_hs;
        send(rand_mat(), rand_vec(), 1'b0);
        check("b2b_interval", 64'(last_hs - h1), 64'(LAT + 2));
        drain(1'b0);

        // Random operand sets with random downstream stalls
        for (int t = 0; t < 20; t++) begin
            out_ready = ($urandom_range(0, 1) == 1);
            send(rand_mat(), rand_vec(), 1'b0);
            drain(1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
